// File: rtl/montgomery_constant_streamer.sv
// Streams the Montgomery constants k and N block by block to the reducer.
// One mcs_lane instance per constant; a shared FSM sequences load, prime and run.

module mcs_lane #(
  parameter int W  = 32,
  parameter int NB = 128,
  parameter int IW = $clog2(NB)
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          prime_start,
  input  logic          active,
  input  logic          consume,
  output logic [W-1:0]  block,
  output logic [IW-1:0] index,
  output logic          wrap
);

  localparam logic [IW-1:0] LAST = IW'(NB - 1);

  logic [W-1:0]  mem [NB];
  logic [W-1:0]  rdata;
  logic [W-1:0]  pf0_q, pf1_q, pf0_d, pf1_d, out_d;
  logic [1:0]    pf_cnt_q, pf_cnt_d;
  logic [2:0]    occ_after;
  logic [IW-1:0] fptr_q;
  logic          rvld_q, out_vld_q;
  logic          issue, to_out, push, pop_pf;

  // Keep prefetch plus in-flight read at two entries: sustains a consume every cycle.
  always_comb begin
    occ_after = {1'b0, pf_cnt_q} + {2'b0, rvld_q} - {2'b0, consume};
    issue     = active && (occ_after < 3'd2);
    to_out    = rvld_q && (!out_vld_q || (consume && pf_cnt_q == 2'd0));
    push      = rvld_q && !to_out;
    pop_pf    = consume && (pf_cnt_q != 2'd0);

    out_d = block;
    if (consume)     out_d = pop_pf ? pf0_q : rdata;
    else if (to_out) out_d = rdata;

    pf0_d    = pf0_q;
    pf1_d    = pf1_q;
    pf_cnt_d = pf_cnt_q;
    if (pop_pf) begin
      pf0_d    = pf1_q;
      pf_cnt_d = pf_cnt_q - 2'd1;
    end
    if (push) begin
      if (pf_cnt_d == 2'd0) pf0_d = rdata;
      else                  pf1_d = rdata;
      pf_cnt_d = pf_cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (we)    mem[waddr] <= wdata;
    if (issue) rdata      <= mem[fptr_q];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      block     <= '0;
      index     <= '0;
      wrap      <= 1'b0;
      pf0_q     <= '0;
      pf1_q     <= '0;
      pf_cnt_q  <= '0;
      rvld_q    <= 1'b0;
      out_vld_q <= 1'b0;
      fptr_q    <= '0;
    end else if (prime_start) begin
      index     <= '0;
      wrap      <= 1'b0;
      pf_cnt_q  <= '0;
      rvld_q    <= 1'b0;
      out_vld_q <= 1'b0;
      fptr_q    <= '0;
    end else begin
      block     <= out_d;
      out_vld_q <= out_vld_q | to_out;
      pf0_q     <= pf0_d;
      pf1_q     <= pf1_d;
      pf_cnt_q  <= pf_cnt_d;
      rvld_q    <= issue;
      if (issue) fptr_q <= (fptr_q == LAST) ? '0 : fptr_q + 1'b1;
      wrap      <= consume && (index == LAST);
      if (consume) index <= (index == LAST) ? '0 : index + 1'b1;
    end
  end

endmodule

module montgomery_constant_streamer #(
  parameter int REGISTER_SIZE = 32,
  parameter int NUM_BLOCKS    = 128,
  parameter int IDX_W         = $clog2(NUM_BLOCKS)
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     load_start_in,
  input  logic                     load_valid_in,
  input  logic                     load_sel_in,
  input  logic [REGISTER_SIZE-1:0] load_block_in,
  input  logic                     rewind_in,
  input  logic                     k_consume_in,
  input  logic                     N_consume_in,
  output logic [REGISTER_SIZE-1:0] k_block_out,
  output logic [REGISTER_SIZE-1:0] N_block_out,
  output logic [IDX_W-1:0]         k_index_out,
  output logic [IDX_W-1:0]         N_index_out,
  output logic                     k_wrap_out,
  output logic                     N_wrap_out,
  output logic                     ready_out,
  output logic                     consume_error_out
);

  localparam int NUM_LANES = 2;
  localparam int CNT_W     = IDX_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_BLOCKS);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t state_q, state_d;
  logic [1:0] prime_cnt_q;
  logic       prime_start, active, loaded_nxt, err_q;

  logic [NUM_LANES-1:0][CNT_W-1:0]         cnt_q, cnt_d;
  logic [NUM_LANES-1:0]                    we, consume, lane_wrap;
  logic [NUM_LANES-1:0][IDX_W-1:0]         waddr, lane_idx;
  logic [NUM_LANES-1:0][REGISTER_SIZE-1:0] lane_blk;

  // Clear happens before the write, so a beat alongside load_start lands in block 0.
  always_comb begin
    cnt_d = cnt_q;
    we    = '0;
    waddr = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (load_start_in) cnt_d[l] = '0;
      if (load_valid_in && (load_sel_in == 1'(l)) && (cnt_d[l] < FULL)) begin
        we[l]    = 1'b1;
        waddr[l] = cnt_d[l][IDX_W-1:0];
        cnt_d[l] = cnt_d[l] + 1'b1;
      end
    end
    loaded_nxt = (cnt_d[0] == FULL) && (cnt_d[1] == FULL);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (loaded_nxt) state_d = PRIME;
      PRIME:   if (prime_cnt_q == 2'd2) state_d = RUN;
      RUN:     if (rewind_in) state_d = PRIME;
      default: state_d = IDLE;
    endcase
    if (load_start_in) state_d = IDLE;
  end

  assign prime_start = (state_d == PRIME) && (state_q != PRIME);
  assign active      = (state_q == PRIME) || (state_q == RUN);
  assign ready_out   = (state_q == RUN);

  // Rewind and load_start both outrank a same-cycle consume.
  assign consume[0] = k_consume_in && ready_out && !rewind_in && !load_start_in;
  assign consume[1] = N_consume_in && ready_out && !rewind_in && !load_start_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      prime_cnt_q <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (prime_start)           prime_cnt_q <= '0;
      else if (state_q == PRIME) prime_cnt_q <= prime_cnt_q + 2'd1;
      if (load_start_in)                               err_q <= 1'b0;
      else if ((k_consume_in || N_consume_in) && !ready_out) err_q <= 1'b1;
    end
  end

  assign consume_error_out = err_q;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mcs_lane #(
      .W  (REGISTER_SIZE),
      .NB (NUM_BLOCKS),
      .IW (IDX_W)
    ) u_lane (
      .clk_in      (clk_in),
      .rst_n_in    (rst_n_in),
      .we          (we[g]),
      .waddr       (waddr[g]),
      .wdata       (load_block_in),
      .prime_start (prime_start),
      .active      (active),
      .consume     (consume[g]),
      .block       (lane_blk[g]),
      .index       (lane_idx[g]),
      .wrap        (lane_wrap[g])
    );
  end

  assign k_block_out = lane_blk[0];
  assign N_block_out = lane_blk[1];
  assign k_index_out = lane_idx[0];
  assign N_index_out = lane_idx[1];
  assign k_wrap_out  = lane_wrap[0];
  assign N_wrap_out  = lane_wrap[1];

endmodule

// File: tb/tb_montgomery_constant_streamer.sv
// Directed bench for montgomery_constant_streamer: load, stream, wrap, rewind, errors, reset.

module tb_montgomery_constant_streamer;

  localparam int RS = 32;
  localparam int NB = 128;
  localparam int IW = $clog2(NB);

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          load_start_in, load_valid_in, load_sel_in;
  logic [RS-1:0] load_block_in;
  logic          rewind_in, k_consume_in, N_consume_in;
  logic [RS-1:0] k_block_out, N_block_out;
  logic [IW-1:0] k_index_out, N_index_out;
  logic          k_wrap_out, N_wrap_out, ready_out, consume_error_out;

  int checks   = 0;
  int failures = 0;

  montgomery_constant_streamer #(
    .REGISTER_SIZE (RS),
    .NUM_BLOCKS    (NB),
    .IDX_W         (IW)
  ) dut (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .load_start_in     (load_start_in),
    .load_valid_in     (load_valid_in),
    .load_sel_in       (load_sel_in),
    .load_block_in     (load_block_in),
    .rewind_in         (rewind_in),
    .k_consume_in      (k_consume_in),
    .N_consume_in      (N_consume_in),
    .k_block_out       (k_block_out),
    .N_block_out       (N_block_out),
    .k_index_out       (k_index_out),
    .N_index_out       (N_index_out),
    .k_wrap_out        (k_wrap_out),
    .N_wrap_out        (N_wrap_out),
    .ready_out         (ready_out),
    .consume_error_out (consume_error_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Interleaved k/N beats; optionally the first k beat carries load_start.
  task automatic load_all(input bit with_start);
    for (int i = 0; i < NB; i++) begin
      load_start_in = with_start && (i == 0);
      load_valid_in = 1'b1;
      load_sel_in   = 1'b0;
      load_block_in = 32'h1000_0000 + i;
      step();
      load_start_in = 1'b0;
      load_sel_in   = 1'b1;
      load_block_in = 32'h2000_0000 + i;
      step();
    end
    load_valid_in = 1'b0;
    chk("ready_low_e0", ready_out, 0);
    step();
    step();
    chk("ready_low_e2", ready_out, 0);
    step();
    chk("ready_high_e3", ready_out, 1);
    chk("k_block0_after_load", k_block_out, 32'h1000_0000);
    chk("N_block0_after_load", N_block_out, 32'h2000_0000);
    chk("k_idx0_after_load", k_index_out, 0);
    chk("N_idx0_after_load", N_index_out, 0);
  endtask

  initial begin
    int ki, ni, wraps;
    rst_n_in = 1'b1;
    load_start_in = 0; load_valid_in = 0; load_sel_in = 0; load_block_in = '0;
    rewind_in = 0; k_consume_in = 0; N_consume_in = 0;

    #2 rst_n_in = 1'b0;
    #1;
    chk("rst_ready", ready_out, 0);
    chk("rst_k_block", k_block_out, 0);
    chk("rst_N_block", N_block_out, 0);
    chk("rst_idx", {k_index_out, N_index_out}, 0);
    chk("rst_wrap", {k_wrap_out, N_wrap_out}, 0);
    chk("rst_err", consume_error_out, 0);
    step(); step();
    #2 rst_n_in = 1'b1;
    step();

    // consume before loading
    k_consume_in = 1'b1;
    step();
    k_consume_in = 1'b0;
    chk("early_consume_err", consume_error_out, 1);
    chk("early_consume_idx", k_index_out, 0);
    step();
    chk("err_sticky", consume_error_out, 1);

    // load with load_start on the first beat: clears error, beat lands in block 0
    load_all(1'b1);
    chk("err_cleared_by_start", consume_error_out, 0);

    // 256 back-to-back N consumes
    wraps = 0;
    for (int j = 0; j < 2 * NB; j++) begin
      N_consume_in = 1'b1;
      step();
      chk("N_stream_idx", N_index_out, (j + 1) % NB);
      chk("N_stream_blk", N_block_out, 32'h2000_0000 + ((j + 1) % NB));
      chk("N_stream_wrap", N_wrap_out, ((j + 1) % NB) == 0);
      if (N_wrap_out) wraps++;
    end
    N_consume_in = 1'b0;
    step();
    chk("N_wrap_cleared", N_wrap_out, 0);
    chk("N_wrap_count", wraps, 2);
    chk("k_held", k_block_out, 32'h1000_0000);
    chk("k_idx_held", k_index_out, 0);

    // k every other cycle, N every cycle
    ki = 0; ni = 0;
    for (int j = 0; j < 20; j++) begin
      N_consume_in = 1'b1;
      k_consume_in = (j % 2) == 0;
      step();
      ni++;
      if ((j % 2) == 0) ki++;
      chk("alt_k_blk", k_block_out, 32'h1000_0000 + ki);
      chk("alt_N_blk", N_block_out, 32'h2000_0000 + ni);
      chk("alt_k_idx", k_index_out, ki);
    end
    k_consume_in = 1'b0;
    while (ni < 57) begin
      step();
      ni++;
    end
    chk("N_idx_57", N_index_out, 57);

    // rewind with a simultaneous consume
    rewind_in = 1'b1;
    step();
    rewind_in = 1'b0;
    N_consume_in = 1'b0;
    chk("rewind_ready_c1", ready_out, 0);
    chk("rewind_no_wrap", N_wrap_out, 0);
    step();
    chk("rewind_ready_c2", ready_out, 0);
    step();
    chk("rewind_ready_c3", ready_out, 0);
    step();
    chk("rewind_ready_c4", ready_out, 1);
    chk("rewind_N_idx", N_index_out, 0);
    chk("rewind_N_blk", N_block_out, 32'h2000_0000);
    chk("rewind_k_idx", k_index_out, 0);
    chk("rewind_no_err", consume_error_out, 0);
    N_consume_in = 1'b1;
    step();
    chk("post_rewind_N_blk", N_block_out, 32'h2000_0001);
    ni = 1;
    while (ni < 90) begin
      step();
      ni++;
    end
    N_consume_in = 1'b0;
    chk("N_idx_90", N_index_out, 90);

    // asynchronous reset mid-stream
    #3 rst_n_in = 1'b0;
    #1;
    chk("async_rst_ready", ready_out, 0);
    chk("async_rst_N_blk", N_block_out, 0);
    chk("async_rst_k_blk", k_block_out, 0);
    chk("async_rst_N_idx", N_index_out, 0);
    #10 rst_n_in = 1'b1;
    for (int j = 0; j < 5; j++) step();
    chk("no_ready_after_rst", ready_out, 0);

    // reload, then consume inside the rewind's prime window
    load_all(1'b0);
    rewind_in = 1'b1;
    step();
    rewind_in = 1'b0;
    N_consume_in = 1'b1;
    step();
    N_consume_in = 1'b0;
    chk("prime_consume_err", consume_error_out, 1);
    step();
    chk("prime_ready_c3", ready_out, 0);
    step();
    chk("prime_ready_c4", ready_out, 1);
    chk("prime_consume_ignored", N_index_out, 0);
    chk("prime_err_sticky", consume_error_out, 1);
    load_start_in = 1'b1;
    step();
    load_start_in = 1'b0;
    chk("start_clears_err", consume_error_out, 0);
    chk("start_drops_ready", ready_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
